// File: rtl/seg7_serial_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_serial_driver: hex-decodes 8 digits and shifts them into a 7-seg chain |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module seg7_serial_driver #(
  parameter int SCLK_DIV   = 4,
  parameter int REFRESH    = 50000,
  parameter int BLINK_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  LE_in,
  input  logic        refresh,
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        seg_pen,
  output logic        seg_clrn,
  output logic        busy
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int RW = $clog2(REFRESH);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t                  state, state_nxt;
  logic [DW-1:0]           div_cnt;
  logic [5:0]              bit_cnt;
  logic                    clk_hi;
  logic [63:0]             shreg;
  logic [63:0]             frame;
  logic [RW-1:0]           ref_cnt;
  logic [BLINK_BITS-1:0]   blink_cnt;
  logic                    div_end;
  logic                    bit_end;
  logic                    tick;

  // Segment patterns {dp,g,f,e,d,c,b,a}, active-low, decimal point off
  function automatic logic [7:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  for (genvar i = 0; i < 8; i++) begin : g_digit
    assign frame[8*i +: 8] = (LE_in[i] && blink_cnt[BLINK_BITS-1]) ? 8'hFF
                           : (hex7(Disp_num[4*i +: 4]) & {~point_in[i], 7'h7F});
  end

  assign div_end = (div_cnt == DIV_LAST);
  assign bit_end = clk_hi && div_end;
  assign tick    = (ref_cnt == REF_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick || refresh) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (bit_end && (bit_cnt == 6'd63)) state_nxt = LATCH;
      LATCH:   if (div_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      clk_hi    <= 1'b0;
      shreg     <= '0;
      ref_cnt   <= '0;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_BITS'(1);
      ref_cnt   <= tick ? '0 : ref_cnt + RW'(1);
      case (state)
        LOAD: begin
          shreg   <= frame;
          div_cnt <= '0;
          bit_cnt <= '0;
          clk_hi  <= 1'b0;
        end
        SHIFT: begin
          // Each bit: SCLK_DIV cycles low, then SCLK_DIV cycles high; shift on the fall
          if (div_end) begin
            div_cnt <= '0;
            clk_hi  <= ~clk_hi;
            if (clk_hi) begin
              shreg   <= {shreg[62:0], 1'b0};
              bit_cnt <= bit_cnt + 6'd1;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        LATCH: div_cnt <= div_end ? '0 : div_cnt + DW'(1);
        default: begin
          div_cnt <= '0;
          clk_hi  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    seg_clrn <= rst;
  end

  assign seg_clk  = (state == SHIFT) && clk_hi;
  assign seg_sout = (state == SHIFT) && shreg[63];
  assign seg_pen  = (state == LATCH);
  assign busy     = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seg7_serial_driver.sv
`default_nettype none
// Bench for seg7_serial_driver: directed and random frames checked against a frame model.
module tb_seg7_serial_driver;
  localparam int SD       = 2;
  localparam int RF       = 4000;
  localparam int BB       = 4;
  localparam int BUSY_LEN = 1 + 128*SD + SD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Disp_num = '0;
  logic [7:0]  point_in = '0;
  logic [7:0]  LE_in = '0;
  logic        refresh = 1'b0;
  logic        seg_clk, seg_sout, seg_pen, seg_clrn, busy;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_serial_driver #(.SCLK_DIV(SD), .REFRESH(RF), .BLINK_BITS(BB)) dut (
    .clk(clk), .rst(rst), .Disp_num(Disp_num), .point_in(point_in), .LE_in(LE_in),
    .refresh(refresh), .seg_clk(seg_clk), .seg_sout(seg_sout), .seg_pen(seg_pen),
    .seg_clrn(seg_clrn), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycles since reset release: drives both the blink phase and the refresh tick
  always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_frame(input logic [31:0] num, input logic [7:0] pt,
                                              input logic [7:0] le, input bit ph);
    logic [63:0] f;
    logic [7:0]  b;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      b = hex_tab[num[4*i +: 4]];
      if (pt[i]) b[7] = 1'b0;
      if (le[i] && ph) b = 8'hFF;
      f[8*i +: 8] = b;
    end
    return f;
  endfunction

  task automatic pulse_refresh;
    @(negedge clk) refresh = 1'b1;
    @(negedge clk) refresh = 1'b0;
  endtask

  // Called at a negedge; watches one whole frame from the LOAD cycle to busy falling
  task automatic frame_check(input string tag, input logic [31:0] num,
                             input logic [7:0] pt, input logic [7:0] le);
    logic [63:0] got;
    int          bcyc, pcyc, pulses, nbits;
    bit          ph, prev_c, prev_p;
    got = '0; bcyc = 0; pcyc = 0; pulses = 0; nbits = 0; prev_c = 0; prev_p = 0;
    for (int i = 0; i < 300 && !busy; i++) @(negedge clk);
    chk({tag, " start"}, 64'(busy), 64'd1);
    ph = ((cyc / (1 << (BB-1))) % 2) == 1;
    for (int i = 0; i < 400 && busy; i++) begin
      bcyc++;
      if (seg_clk && !prev_c) begin
        got = {got[62:0], seg_sout};
        nbits++;
      end
      if (seg_pen) begin
        pcyc++;
        if (!prev_p) pulses++;
      end
      prev_c = seg_clk;
      prev_p = seg_pen;
      @(negedge clk);
    end
    chk({tag, " data"}, got, model_frame(num, pt, le, ph));
    chk({tag, " bits"}, 64'(nbits), 64'd64);
    chk({tag, " busy_len"}, 64'(bcyc), 64'(BUSY_LEN));
    chk({tag, " pen_len"}, 64'(pcyc), 64'(SD));
    chk({tag, " pen_pulses"}, 64'(pulses), 64'd1);
  endtask

  initial begin
    int extra, rises, pens;
    logic [31:0] rn;
    logic [7:0]  rp, rl;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst seg_clk", 64'(seg_clk), 64'd0);
    chk("rst seg_pen", 64'(seg_pen), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst seg_clrn", 64'(seg_clrn), 64'd0);
    chk("rst seg_sout", 64'(seg_sout), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("release seg_clrn", 64'(seg_clrn), 64'd1);
    chk("release busy", 64'(busy), 64'd0);

    Disp_num = 32'h01234567;
    pulse_refresh();
    frame_check("hex0_7", 32'h01234567, 8'h00, 8'h00);

    Disp_num = 32'hFFFFFFFF; point_in = 8'h01;
    pulse_refresh();
    frame_check("allF_dp0", 32'hFFFFFFFF, 8'h01, 8'h00);

    Disp_num = 32'h88888888; point_in = 8'h00; LE_in = 8'h80;
    for (int k = 0; k < 4; k++) begin
      pulse_refresh();
      frame_check("blink7", 32'h88888888, 8'h00, 8'h80);
    end

    Disp_num = 32'h01234567; LE_in = 8'h00;
    pulse_refresh();
    fork
      frame_check("midchange", 32'h01234567, 8'h00, 8'h00);
      begin
        repeat (100) @(negedge clk);
        Disp_num = 32'h0;
      end
    join
    pulse_refresh();
    frame_check("zeros", 32'h0, 8'h00, 8'h00);

    for (int r = 0; r < 3; r++) begin
      rn = $urandom; rp = 8'($urandom); rl = 8'($urandom);
      Disp_num = rn; point_in = rp; LE_in = rl;
      pulse_refresh();
      frame_check("random", rn, rp, rl);
    end

    // Refresh request while busy is dropped
    Disp_num = 32'hA5A5C3C3; point_in = 8'h5A; LE_in = 8'h00;
    pulse_refresh();
    fork
      frame_check("busy_refresh", 32'hA5A5C3C3, 8'h5A, 8'h00);
      begin
        repeat (60) @(negedge clk);
        refresh = 1'b1;
        @(negedge clk) refresh = 1'b0;
      end
    join
    extra = 0;
    repeat (30) begin @(negedge clk); if (busy) extra++; end
    chk("no queued refresh", 64'(extra), 64'd0);

    // Counter tick falling inside a frame is dropped
    for (int i = 0; i < 4100 && (cyc % RF) != RF - 101; i++) @(negedge clk);
    pulse_refresh();
    frame_check("tick_in_busy", 32'hA5A5C3C3, 8'h5A, 8'h00);
    extra = 0;
    repeat (50) begin @(negedge clk); if (busy) extra++; end
    chk("no queued tick", 64'(extra), 64'd0);

    // Next tick while idle starts a frame on its own
    for (int i = 0; i < 4100 && (cyc % RF) != RF - 1; i++) @(negedge clk);
    chk("idle before tick", 64'(busy), 64'd0);
    @(negedge clk);
    chk("tick starts frame", 64'(busy), 64'd1);
    frame_check("tick_frame", 32'hA5A5C3C3, 8'h5A, 8'h00);

    // Reset in the middle of SHIFT aborts the frame
    pulse_refresh();
    repeat (60) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort seg_clk", 64'(seg_clk), 64'd0);
    chk("abort seg_pen", 64'(seg_pen), 64'd0);
    chk("abort seg_clrn", 64'(seg_clrn), 64'd0);
    rst = 1'b1;
    rises = 0; pens = 0; extra = 0;
    begin
      bit prev;
      prev = seg_clk;
      repeat (300) begin
        @(negedge clk);
        if (seg_clk && !prev) rises++;
        if (seg_pen) pens++;
        if (busy) extra++;
        prev = seg_clk;
      end
    end
    chk("abort no seg_clk", 64'(rises), 64'd0);
    chk("abort no pen", 64'(pens), 64'd0);
    chk("abort stays idle", 64'(extra), 64'd0);
    chk("abort seg_clrn back", 64'(seg_clrn), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
